// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit.
// Operation encoding used by operand preparation.
package adder_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ADC = 2'd2,
        RSV = 2'd3
    } op_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple adder built from full-adder equations.
// Also exposes the carry into its MSB for overflow detection.
module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    logic cy;

    always_comb begin
        sum  = '0;
        cmsb = 1'b0;
        cy   = cin;
        for (int i = 0; i < SW; i++) begin
            if (i == SW - 1) cmsb = cy;
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        cout = cy;
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: one SW-bit slice resolved per stage.
// Define ADDER_PIPE_SAT_EN for signed saturation on overflow.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic [OP_W-1:0]  op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] res_o,
    output logic             c_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int SW = WIDTH / STAGES;

    logic             stall;
    logic [WIDTH-1:0] b0;
    logic             c0;

    assign stall      = out_valid_o && !out_ready_i;
    assign in_ready_o = !stall;

    always_comb begin
        b0 = b_i;
        c0 = 1'b0;
        unique case (op_t'(op_i))
            SUB: begin
                b0 = ~b_i;
                c0 = 1'b1;
            end
            ADC: c0 = c_i;
            ADD, RSV: ;
        endcase
    end

    // Stage k consumes the lowest remaining slice; upper slices ride along.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int WK = WIDTH - k * SW;
        localparam int WS = (k + 1) * SW;

        logic          v_in;
        logic          c_in;
        logic [WK-1:0] a_in;
        logic [WK-1:0] b_in;
        logic [SW-1:0] sum;
        logic          co;
        logic          cm;
        logic [WS-1:0] s_nx;
        logic          v_q;
        logic          c_q;
        logic [WS-1:0] s_q;

        if (k == 0) begin : g_head
            assign v_in = in_valid_i;
            assign c_in = c0;
            assign a_in = a_i;
            assign b_in = b0;
            assign s_nx = sum;
        end else begin : g_body
            assign v_in = g_stage[k-1].v_q;
            assign c_in = g_stage[k-1].c_q;
            assign a_in = g_stage[k-1].g_skew.a_q;
            assign b_in = g_stage[k-1].g_skew.b_q;
            assign s_nx = {sum, g_stage[k-1].s_q};
        end

        adder_slice #(
            .SW(SW)
        ) u_slice (
            .a   (a_in[SW-1:0]),
            .b   (b_in[SW-1:0]),
            .cin (c_in),
            .sum (sum),
            .cout(co),
            .cmsb(cm)
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (!stall) begin
                v_q <= v_in;
                c_q <= co;
                s_q <= s_nx;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WK-SW-1:0] a_q;
            logic [WK-SW-1:0] b_q;
            logic             unused_cm;

            assign unused_cm = cm;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_in[WK-1:SW];
                    b_q <= b_in[WK-1:SW];
                end
            end
        end else begin : g_tail
            logic ovf_q;
            logic zero_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q  <= cm ^ co;
                    zero_q <= (s_nx == '0);
                end
            end
        end
    end

    logic [WIDTH-1:0] sum_q;
    logic             ovf_q;
    logic             zero_q;

    assign sum_q       = g_stage[STAGES-1].s_q;
    assign ovf_q       = g_stage[STAGES-1].g_tail.ovf_q;
    assign zero_q      = g_stage[STAGES-1].g_tail.zero_q;
    assign out_valid_o = g_stage[STAGES-1].v_q;
    assign c_o         = g_stage[STAGES-1].c_q;
    assign ovf_o       = ovf_q;

`ifdef ADDER_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // A wrapped MSB of 1 means the true result was positive.
    assign res_o  = !ovf_q ? sum_q : (sum_q[WIDTH-1] ? MAX_POS : MIN_NEG);
    assign zero_o = zero_q && !ovf_q;
`else
    assign res_o  = sum_q;
    assign zero_o = zero_q;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed cases, back-pressure,
// randomized traffic against an arithmetic model, and mid-stream reset.
module tb_adder_pipe;
    import adder_pkg::*;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         c_out;
    logic         ovf;
    logic         zero;

    int errors = 0;
    int checks = 0;
    int sent = 0;
    int recv = 0;
    int dropped = 0;

    logic [W+2:0] exp_q[$];
    bit           rnd = 0;
    bit           bp_arm = 0;
    bit           bp_done = 0;
    int           bp_cnt = 0;
    logic [W-1:0] bp_res;
    logic [W-1:0] corner[6];

    always #5 clk = ~clk;

    adder_pipe #(
        .WIDTH (W),
        .STAGES(S)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .a_i        (a),
        .b_i        (b),
        .c_i        (c_in),
        .op_i       (op),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .res_o      (res),
        .c_o        (c_out),
        .ovf_o      (ovf),
        .zero_o     (zero)
    );

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Returns {zero, ovf, carry, result} from plain integer arithmetic.
    function automatic logic [W+2:0] model(logic [1:0] o, logic [W-1:0] x,
                                           logic [W-1:0] y, logic ci);
        logic [W:0]   full;
        logic [W-1:0] yy;
        logic [W-1:0] r;
        logic         cc;
        logic         v;
        yy = y;
        cc = 1'b0;
        if (o == 2'd1) begin
            yy = ~y;
            cc = 1'b1;
        end else if (o == 2'd2) begin
            cc = ci;
        end
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        r = full[W-1:0];
        v = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
`ifdef ADDER_PIPE_SAT_EN
        if (v) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {r == '0, v, full[W], r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bp_cnt > 0) begin
            check("bp_res_stable", res, bp_res);
            check("bp_in_ready", {31'd0, in_ready}, 0);
            bp_cnt--;
            if (bp_cnt == 0) out_ready = 1'b1;
        end else if (bp_arm && !bp_done && out_valid) begin
            out_ready = 1'b0;
            bp_res = res;
            bp_cnt = 3;
            bp_done = 1'b1;
        end else if (rnd) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic send(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic ci);
        bit ok;
        ok = 1'b0;
        op = o;
        a = x;
        b = y;
        c_in = ci;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(o, x, y, ci));
                sent++;
                ok = 1'b1;
            end
            tick();
        end
        check("send_accepted", {31'd0, ok}, 1);
        in_valid = 1'b0;
    endtask

    task automatic one(string tag, logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y,
                       logic ci, logic [W-1:0] er, logic ec, logic eo, logic ez);
        int n;
        send(o, x, y, ci);
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, S);
        check({tag, "_res"}, res, er);
        check({tag, "_c"}, {31'd0, c_out}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        logic [W+2:0] e;
        if (rst_n && out_valid && out_ready) begin
            recv++;
            check("out_expected", {31'd0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_res", res, e[W-1:0]);
                check("sb_c", {31'd0, c_out}, {31'd0, e[W]});
                check("sb_ovf", {31'd0, ovf}, {31'd0, e[W+1]});
                check("sb_zero", {31'd0, zero}, {31'd0, e[W+2]});
            end
        end
    end

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] sat_exp;

        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h0000_0001;
        corner[5] = 32'h00FF_FF00;

        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        c_in = 1'b0;
        op = 2'd0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_res", res, 0);
        check("rst_c", {31'd0, c_out}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        check("rst_zero", {31'd0, zero}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        one("add_ff", 2'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0,
            32'h0000_0100, 1'b0, 1'b0, 1'b0);
        one("sub_eq", 2'd1, 32'd5, 32'd5, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
`ifdef ADDER_PIPE_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'h8000_0000;
`endif
        one("add_ovf", 2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0,
            sat_exp, 1'b0, 1'b1, 1'b0);
        one("adc_ripple", 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b1,
            32'd0, 1'b1, 1'b0, 1'b1);
        one("rsv_as_add", 2'd3, 32'h1234_5678, 32'h1111_1111, 1'b1,
            32'h2345_6789, 1'b0, 1'b0, 1'b0);

        bp_arm = 1'b1;
        for (int i = 0; i < 6; i++) send(2'd0, 32'h1000 * (i + 1), 32'd7 + i, 1'b0);
        drain();
        bp_arm = 1'b0;
        check("bp_triggered", {31'd0, bp_done}, 1);

        rnd = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            send(ro, ra, rb, 1'($urandom_range(0, 1)));
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        drain();

        for (int i = 0; i < 4; i++) send(2'd0, 32'd100 + i, 32'd1, 1'b0);
        check("mid_pre_valid", {31'd0, out_valid}, 1);
        rst_n = 1'b0;
        dropped = exp_q.size();
        exp_q.delete();
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 0);
        check("mid_rst_res", res, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready", {31'd0, in_ready}, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale", {31'd0, out_valid}, 0);
        end
        one("fresh", 2'd1, 32'd10, 32'd3, 1'b0, 32'd7, 1'b1, 1'b0, 1'b0);
        drain();
        check("count_match", recv, sent - dropped);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined N-bit add/subtract unit. It is the successor to the single-bit full-adder cell.
- Operands are split into STAGES slices. One slice is resolved per cycle, and the carry ripples between pipeline registers.
- Accepts one operation per cycle through a valid/ready handshake and returns the result with carry, overflow and zero flags.
- Sits between the operand-fetch logic and the result writeback path of the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of STAGES.
- STAGES, 4, pipeline depth and slice count. Slice width SW = WIDTH/STAGES. Range 1..WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  operation presented.
- in_ready_o  out  1  unit can accept an operation this cycle.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- c_i  in  1  carry-in; used only by op ADC.
- op_i  in  2  operation code (op_t): ADD=0, SUB=1, ADC=2, RSV=3.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- res_o  out  WIDTH  sum/difference.
- c_o  out  1  carry-out of the MSB. For SUB, 1 means no borrow.
- ovf_o  out  1  signed overflow.
- zero_o  out  1  res_o == 0.

Behaviour:
- Reset: while rst_ni is low, all valid bits clear immediately. out_valid_o=0, res_o=0, c_o=0, ovf_o=0, zero_o=0. Data registers reset to 0.
- Reset mid-operation: in-flight operations are discarded, not completed. in_ready_o=1 after release.
- Operand preparation at entry:
  - ADD: b'=b_i, cin=0.
  - SUB: b'=~b_i, cin=1.
  - ADC: b'=b_i, cin=c_i.
  - RSV: treated as ADD.
- Stage k (0..STAGES-1):
  - Adds slice k of A and b' plus the carry from stage k-1 (cin for k=0).
  - Registers the SW-bit partial sum and its carry.
  - Higher slices travel unmodified in skew registers until their stage.
- Latency: exactly STAGES cycles from the accepting edge (in_valid_i && in_ready_o) to out_valid_o=1, when no stall occurs.
- Throughput: one operation per cycle.
- Handshake:
  - stall = out_valid_o && !out_ready_i.
  - in_ready_o = !stall, combinational. This is a global stall; no bubble collapsing.
  - During a stall, all stage registers hold and outputs stay stable.
  - Bubbles (valid=0) advance like data.
  - A transfer occurs when out_valid_o && out_ready_i.
  - Accept and transfer may coincide in the same cycle.
- Flags:
  - Registered with the final slice.
  - ovf_o = carry into MSB XOR carry out of MSB.
  - zero_o is computed from the full assembled result.
- Arithmetic: modulo 2^WIDTH; no exceptions.
- STAGES=1 degenerates to a registered full-width adder with latency 1.
- in_valid_i=1 while in_ready_o=0: the operation is not captured. The source must hold its inputs.
- Simultaneous reset and valid: reset wins.

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN.
- When defined:
  - On overflow, res_o saturates to the signed limit: 0x7FF..F if the true result is positive, 0x800..0 if negative.
  - ovf_o still reports the overflow.
  - Saturation is applied combinationally at the output from the registered sign/overflow information. Latency is unchanged.
- When undefined: wrap-around result only; no saturation logic is present.

Decomposition:
- Package adder_pkg:
  - op_t enum (ADD, SUB, ADC, RSV).
  - localparam-friendly helper constant OP_W=2.
- Sub-module adder_slice:
  - Combinational SW-bit ripple adder with ports a, b, cin, sum, cout and carry-into-MSB.
  - Built from bitwise full-adder equations.
  - Instantiated once per stage.

Test Plan (WIDTH=32, STAGES=4):
- ADD 0x0000_00FF + 0x0000_0001, out_ready_i=1 -> after exactly 4 cycles: res_o=0x0000_0100, c_o=0, ovf_o=0, zero_o=0.
- SUB 5-5 -> res_o=0, zero_o=1, c_o=1.
- ADD 0x7FFF_FFFF + 1 -> res_o=0x8000_0000, ovf_o=1. With ADDER_PIPE_SAT_EN -> res_o=0x7FFF_FFFF, ovf_o=1.
- ADC 0xFFFF_FFFF + 0 with c_i=1 -> res_o=0, c_o=1; the carry crosses all slice boundaries.
- Back-pressure:
  - Stream 6 back-to-back ADDs and hold out_ready_i=0 for 3 cycles once out_valid_o rises.
  - Required: in_ready_o=0 during the stall, res_o stable.
  - All 6 results appear in order with no loss or duplication.
- Reset mid-stream: assert rst_ni=0 with 3 operations in flight -> out_valid_o=0 immediately. No stale result emerges after release, and a fresh operation completes in 4 cycles.
